// File: rtl/alu_req_sched.sv
// alu_req_sched: round-robin scheduler sharing one non-pipelined ALU between two requesters,
// one operation in flight, tagged response on a shared valid/ready channel.
module alu_req_sched #(
  parameter int ALU_LAT = 1,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [3:0]      req0_sel,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [3:0]      req1_sel,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [3:0]      alu_sel,
  input  logic [2*DW-1:0] alu_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [2*DW-1:0] rsp_data,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  localparam logic [3:0] LAT = 4'(ALU_LAT);
  state_t state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [3:0] sel_q, sel_d, lat_q, lat_d;
  logic id_q, id_d, rr_q, rr_d, rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [2*DW-1:0] rsp_data_q, rsp_data_d;
  logic gnt, acc, done, hs;
  // a lone requester wins outright; rr_q only breaks ties
  assign gnt = (req0_valid && req1_valid) ? rr_q : req1_valid;
  assign acc = req0_ready || req1_ready;
  assign done = state_q == EXEC && lat_q == LAT;
  assign hs = state_q == RESP && rsp_ready;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (acc ? EXEC : IDLE) :
              state_q == EXEC ? (done ? RESP : EXEC) :
              (hs ? IDLE : RESP);
  end
  always_comb begin
    req0_ready = !rst && state_q == IDLE && req0_valid && !gnt;
    req1_ready = !rst && state_q == IDLE && req1_valid && gnt;
    busy = state_q != IDLE;
  end
  always_comb begin
    a_d = acc ? (gnt ? req1_a : req0_a) : a_q;
    b_d = acc ? (gnt ? req1_b : req0_b) : b_q;
    sel_d = acc ? (gnt ? req1_sel : req0_sel) : sel_q;
    id_d = acc ? gnt : id_q;
    lat_d = acc ? 4'd0 : state_q == EXEC ? lat_q + 4'd1 : lat_q;
    rsp_valid_d = done ? 1'b1 : hs ? 1'b0 : rsp_valid_q;
    rsp_id_d = done ? id_q : rsp_id_q;
    rsp_data_d = done ? alu_out : rsp_data_q;
    rr_d = hs ? ~rsp_id_q : rr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      id_q <= 1'b0;
      lat_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_data_q <= '0;
      rr_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      sel_q <= sel_d;
      id_q <= id_d;
      lat_q <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rr_q <= rr_d;
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_sel = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_data = rsp_data_q;
endmodule

// File: tb/tb_alu_req_sched.sv
// tb_alu_req_sched: transaction-level reference model with randomized and directed stimulus
// for a 1-cycle ALU instance, plus a latency sweep on a 3-cycle ALU instance.
module tb_alu_req_sched;
  localparam int LAT = 1;
  logic clk = 1'b0, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic [3:0] req0_sel, req1_sel, alu_sel;
  logic [63:0] alu_out, rsp_data;
  logic rsp_valid, rsp_ready, rsp_id, busy;
  logic x_req0_valid, x_req0_ready, x_req1_valid, x_req1_ready;
  logic [31:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b, x_alu_a, x_alu_b;
  logic [3:0] x_req0_sel, x_req1_sel, x_alu_sel;
  logic [63:0] x_alu_out, x_p1, x_p2, x_rsp_data;
  logic x_rsp_valid, x_rsp_ready, x_rsp_id, x_busy;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, n;
  bit inflt = 0, fid = 0, pref = 0, acc0 = 0, acc1 = 0;
  logic [31:0] fa, fb, la = '0, lb = '0, sum;
  logic [3:0] fs, ls = '0;
  bit served[$];
  int hs_cyc[$];
  always #5 clk = ~clk;
  alu_req_sched #(.ALU_LAT(1), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );
  alu_req_sched #(.ALU_LAT(3), .DW(32)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_a(x_req0_a), .req0_b(x_req0_b), .req0_sel(x_req0_sel),
    .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_a(x_req1_a), .req1_b(x_req1_b), .req1_sel(x_req1_sel),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_sel(x_alu_sel), .alu_out(x_alu_out),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_id(x_rsp_id), .rsp_data(x_rsp_data), .busy(x_busy)
  );
  always_ff @(posedge clk) alu_out <= {32'h0, alu_a + alu_b};
  always_ff @(posedge clk) begin
    x_p1 <= {28'h0, x_alu_sel, x_alu_a + x_alu_b};
    x_p2 <= x_p1;
    x_alu_out <= x_p2;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // One clock: compare DUT against the model for the current cycle, then advance the model.
  task automatic tick();
    bit e0, e1, erv;
    #1;
    erv = inflt && (cyc >= acc_cyc + LAT + 1);
    e0 = !rst && !inflt && req0_valid && !(req1_valid && pref);
    e1 = !rst && !inflt && req1_valid && !(req0_valid && !pref);
    sum = fa + fb;
    chk("req0_ready", 64'(req0_ready), 64'(e0));
    chk("req1_ready", 64'(req1_ready), 64'(e1));
    chk("busy", 64'(busy), 64'(inflt));
    chk("rsp_valid", 64'(rsp_valid), 64'(erv));
    if (erv) begin
      chk("rsp_id", 64'(rsp_id), 64'(fid));
      chk("rsp_data", rsp_data, {32'h0, sum});
    end
    chk("alu_a", 64'(alu_a), 64'(la));
    chk("alu_b", 64'(alu_b), 64'(lb));
    chk("alu_sel", 64'(alu_sel), 64'(ls));
    @(posedge clk);
    cyc++;
    acc0 = 0;
    acc1 = 0;
    if (rst) begin
      inflt = 0; pref = 0; la = '0; lb = '0; ls = '0;
    end else if (e0 || e1) begin
      inflt = 1; acc_cyc = cyc; fid = e1; acc0 = e0; acc1 = e1;
      fa = e1 ? req1_a : req0_a;
      fb = e1 ? req1_b : req0_b;
      fs = e1 ? req1_sel : req0_sel;
      la = fa; lb = fb; ls = fs;
    end else if (erv && rsp_ready) begin
      inflt = 0; pref = !fid;
      served.push_back(fid);
      hs_cyc.push_back(cyc);
    end
    @(negedge clk);
  endtask
  task automatic rnd_drive();
    if (acc0 || !req0_valid) begin
      req0_valid = $urandom_range(0, 2) != 0;
      req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom);
    end else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
    if (acc1 || !req1_valid) begin
      req1_valid = $urandom_range(0, 2) != 0;
      req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom);
    end else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
    rsp_ready = $urandom_range(0, 3) != 0;
  endtask
  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = $urandom;
    req0_a = $urandom; req0_b = $urandom; req0_sel = 4'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_sel = 4'($urandom);
    x_req0_valid = 1'b0; x_req1_valid = 1'b0; x_rsp_ready = 1'b1;
    x_req0_a = '0; x_req0_b = '0; x_req0_sel = '0;
    x_req1_a = '0; x_req1_b = '0; x_req1_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_alu_sel", 64'(alu_sel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_x_busy", 64'(x_busy), 64'd0);
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = 32'h1234ABCD; req0_b = 32'h00FF00FF; req0_sel = 4'h0;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("single_lat", 64'(n), 64'd2);
    chk("single_data", rsp_data, 64'h000000001333ACCC);
    chk("single_id", 64'(rsp_id), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    served.delete();
    hs_cyc.delete();
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sel = 4'h3;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sel = 4'h9;
    repeat (16) tick();
    chk("cont_count", 64'(served.size()), 64'd4);
    for (int i = 0; i < served.size(); i++) chk("cont_id", 64'(served[i]), 64'(i % 2));
    for (int i = 1; i < hs_cyc.size(); i++) chk("cont_period", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd4);
    req1_valid = 1'b0;
    repeat (4) begin tick(); if (acc0) req0_valid = 1'b0; end
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick(); n++; end
    chk("bp_lat", 64'(n), 64'd2);
    req1_valid = 1'b1; req1_a = $urandom; req1_b = $urandom;
    repeat (5) tick();
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 64'(rsp_valid), 64'd0);
    repeat (4) begin tick(); if (acc1) req1_valid = 1'b0; end
    req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    repeat (6) begin tick(); if (rsp_valid) n++; end
    chk("rstmid_no_rsp", 64'(n), 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 chk("rstmid_grant0", 64'(req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    repeat (3000) begin rnd_drive(); tick(); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) tick();
    x_rsp_ready = 1'b1;
    for (int s = 0; s < 16; s++) begin
      x_req0_valid = 1'b1; x_req0_a = $urandom; x_req0_b = $urandom; x_req0_sel = 4'(s);
      sum = x_req0_a + x_req0_b;
      #1 chk("lat3_ready", 64'(x_req0_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      x_req0_valid = 1'b0;
      n = 0;
      while (!x_rsp_valid && n < 20) begin
        chk("lat3_sel", 64'(x_alu_sel), 64'(s));
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      chk("lat3_lat", 64'(n), 64'd4);
      chk("lat3_data", x_rsp_data, {28'h0, 4'(s), sum});
      chk("lat3_id", 64'(x_rsp_id), 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
